// File: rtl/station_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// station_cmd_ctrl
//
// Purpose:
//   Consumes GO-to-station / STOP commands from the command link and station
//   IDs from the barcode reader. While in transit it drives o_go (gated by
//   i_OK2Move). It halts and pulses o_send_resp on arrival at the latched
//   destination or on STOP. A piezo is driven at a fixed rate while in transit
//   but blocked by an obstacle.
//
// Ports:
//   i_clk          system clock, all state on posedge
//   i_rst_n        asynchronous active-low reset
//   i_cmd[15:0]    command word, valid while i_cmd_rdy=1
//                  [15:14] op: 01=GO, 00=STOP, 1x=ignored; [5:0] destination
//   i_cmd_rdy      command present, held until o_clr_cmd_rdy is seen
//   o_clr_cmd_rdy  1-cycle pulse: command consumed
//   i_ID[7:0]      station ID, valid while i_ID_vld=1
//   i_ID_vld       station ID present, held until o_clr_ID_vld is seen
//   o_clr_ID_vld   1-cycle pulse: station ID consumed
//   i_OK2Move      1 = path clear, 0 = obstacle
//   o_go           motion core may drive forward
//   o_send_resp    1-cycle pulse: acknowledge to host (arrived or stopped)
//   o_buzz         piezo drive
//   o_buzz_n       complement of o_buzz
//
// Parameter:
//   BUZZ_HALF      clk cycles per buzzer half-period (>= 2)
// -----------------------------------------------------------------------------
module station_cmd_ctrl #(
   parameter int BUZZ_HALF = 12500
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_cmd,
   input  logic        i_cmd_rdy,
   output logic        o_clr_cmd_rdy,
   input  logic [7:0]  i_ID,
   input  logic        i_ID_vld,
   output logic        o_clr_ID_vld,
   input  logic        i_OK2Move,
   output logic        o_go,
   output logic        o_send_resp,
   output logic        o_buzz,
   output logic        o_buzz_n
);

   localparam int                CNT_W  = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
   localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(BUZZ_HALF - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      MOVING = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [5:0]       r_dest;
   logic [5:0]       w_dest_nxt;
   logic             r_in_transit;
   logic             w_in_transit_nxt;
   logic [CNT_W-1:0] r_buzz_cnt;
   logic             r_buzz;

   logic [1:0]       w_op;
   logic             w_is_go;
   logic             w_is_stop;
   logic             w_id_match;
   logic             w_buzz_en;
   logic             w_unused_cmd_bits;

   assign w_op      = i_cmd[15:14];
   assign w_is_go   = (w_op == 2'b01);
   assign w_is_stop = (w_op == 2'b00);

   // Station IDs above 63 can never match a 6-bit destination.
   assign w_id_match = (i_ID[7:6] == 2'b00) && (i_ID[5:0] == r_dest);

   // Middle command bits carry no meaning for this block.
   assign w_unused_cmd_bits = ^i_cmd[13:6];

   // State / destination / transit flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_dest       <= 6'h00;
         r_in_transit <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_dest       <= w_dest_nxt;
         r_in_transit <= w_in_transit_nxt;
      end
   end

   // Next state and handshake outputs. A command always wins over a pending
   // station ID; the ID stays asserted upstream and is taken on a later cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_dest_nxt       = r_dest;
      w_in_transit_nxt = r_in_transit;
      o_clr_cmd_rdy    = 1'b0;
      o_clr_ID_vld     = 1'b0;
      o_send_resp      = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_cmd_rdy) begin
               o_clr_cmd_rdy = 1'b1;
               if (w_is_go) begin
                  w_dest_nxt       = i_cmd[5:0];
                  w_in_transit_nxt = 1'b1;
                  w_state_nxt      = MOVING;
               end
            end else if (i_ID_vld) begin
               o_clr_ID_vld = 1'b1;
            end
         end

         MOVING: begin
            if (i_cmd_rdy) begin
               o_clr_cmd_rdy = 1'b1;
               if (w_is_go) begin
                  w_dest_nxt = i_cmd[5:0];
               end else if (w_is_stop) begin
                  o_send_resp      = 1'b1;
                  w_in_transit_nxt = 1'b0;
                  w_state_nxt      = IDLE;
               end
            end else if (i_ID_vld) begin
               o_clr_ID_vld = 1'b1;
               if (w_id_match) begin
                  o_send_resp      = 1'b1;
                  w_in_transit_nxt = 1'b0;
                  w_state_nxt      = IDLE;
               end
            end
         end

         default: begin
            w_state_nxt      = IDLE;
            w_in_transit_nxt = 1'b0;
         end
      endcase
   end

   assign o_go = r_in_transit & i_OK2Move;

   // Buzzer: toggles every BUZZ_HALF enabled cycles, parks low when disabled.
   assign w_buzz_en = r_in_transit & ~i_OK2Move;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buzz_cnt <= '0;
         r_buzz     <= 1'b0;
      end else if (!w_buzz_en) begin
         r_buzz_cnt <= '0;
         r_buzz     <= 1'b0;
      end else if (r_buzz_cnt == CNT_TC) begin
         r_buzz_cnt <= '0;
         r_buzz     <= ~r_buzz;
      end else begin
         r_buzz_cnt <= r_buzz_cnt + CNT_W'(1);
      end
   end

   assign o_buzz   = r_buzz;
   assign o_buzz_n = ~r_buzz;

endmodule

// File: tb/tb_station_cmd_ctrl.sv
module tb_station_cmd_ctrl;

   localparam int BH = 4;

   logic        i_clk;
   logic        i_rst_n;
   logic [15:0] i_cmd;
   logic        i_cmd_rdy;
   logic        o_clr_cmd_rdy;
   logic [7:0]  i_ID;
   logic        i_ID_vld;
   logic        o_clr_ID_vld;
   logic        i_OK2Move;
   logic        o_go;
   logic        o_send_resp;
   logic        o_buzz;
   logic        o_buzz_n;

   int errors = 0;
   int checks = 0;

   // Reference model: travel status, destination as a plain number, and the
   // length of the current run of blocked-in-transit cycles.
   bit m_moving;
   int m_dest;
   int m_blocked_run;

   station_cmd_ctrl #(.BUZZ_HALF(BH)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_cmd        (i_cmd),
      .i_cmd_rdy    (i_cmd_rdy),
      .o_clr_cmd_rdy(o_clr_cmd_rdy),
      .i_ID         (i_ID),
      .i_ID_vld     (i_ID_vld),
      .o_clr_ID_vld (o_clr_ID_vld),
      .i_OK2Move    (i_OK2Move),
      .o_go         (o_go),
      .o_send_resp  (o_send_resp),
      .o_buzz       (o_buzz),
      .o_buzz_n     (o_buzz_n)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs (called at a negedge), check the combinational
   // and registered outputs against the model, then advance the model.
   task automatic step(input logic cr, input logic [15:0] c, input logic iv,
                       input logic [7:0] id, input logic ok);
      bit is_go, is_stop, e_resp, e_buzz;
      i_cmd_rdy = cr;
      i_cmd     = c;
      i_ID_vld  = iv;
      i_ID      = id;
      i_OK2Move = ok;
      #1;
      is_go   = cr && (c[15:14] == 2'd1);
      is_stop = cr && (c[15:14] == 2'd0);
      e_resp  = m_moving && (is_stop || (!cr && iv && (int'(id) == m_dest)));
      e_buzz  = ((m_blocked_run / BH) % 2) == 1;
      chk("clr_cmd_rdy", 32'(o_clr_cmd_rdy), 32'(cr));
      chk("clr_ID_vld",  32'(o_clr_ID_vld),  32'(!cr && iv));
      chk("send_resp",   32'(o_send_resp),   32'(e_resp));
      chk("go",          32'(o_go),          32'(m_moving && ok));
      chk("buzz",        32'(o_buzz),        32'(e_buzz));
      chk("buzz_n",      32'(o_buzz_n),      32'(!e_buzz));
      @(posedge i_clk);
      m_blocked_run = (m_moving && !ok) ? m_blocked_run + 1 : 0;
      if (is_go) begin
         m_dest   = int'(c[5:0]);
         m_moving = 1'b1;
      end else if (e_resp) begin
         m_moving = 1'b0;
      end
      @(negedge i_clk);
   endtask

   task automatic idle_step(input logic ok);
      step(1'b0, 16'h0000, 1'b0, 8'h00, ok);
   endtask

   // Assert reset at a negedge, check outputs while held, release a cycle later.
   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_cmd_rdy = 1'b0;
      i_ID_vld  = 1'b0;
      i_cmd     = 16'h0000;
      i_ID      = 8'h00;
      #1;
      chk("rst_go",        32'(o_go),          32'd0);
      chk("rst_buzz",      32'(o_buzz),        32'd0);
      chk("rst_buzz_n",    32'(o_buzz_n),      32'd1);
      chk("rst_clr_cmd",   32'(o_clr_cmd_rdy), 32'd0);
      chk("rst_clr_id",    32'(o_clr_ID_vld),  32'd0);
      chk("rst_send_resp", 32'(o_send_resp),   32'd0);
      m_moving      = 1'b0;
      m_dest        = 0;
      m_blocked_run = 0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      chk("rst_dest", 32'(dut.r_dest), 32'd0);
      @(negedge i_clk);
   endtask

   initial begin
      logic        cr, iv, ok;
      logic [15:0] c;
      logic [7:0]  id;

      i_rst_n   = 1'b1;
      i_cmd     = 16'h0000;
      i_cmd_rdy = 1'b0;
      i_ID      = 8'h00;
      i_ID_vld  = 1'b0;
      i_OK2Move = 1'b1;
      @(negedge i_clk);
      do_reset();

      // GO to 0x05
      step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1);
      idle_step(1'b1);

      // Non-matching then matching ID
      step(1'b0, 16'h0000, 1'b1, 8'h03, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 8'h05, 1'b1);
      idle_step(1'b1);

      // STOP while moving, then ignored op in IDLE
      step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1);
      step(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1);
      idle_step(1'b1);
      step(1'b1, 16'hC005, 1'b0, 8'h00, 1'b1);
      idle_step(1'b1);

      // Blocked while moving: buzzer runs, then clears
      step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 20; k++) idle_step(1'b0);
      idle_step(1'b1);
      idle_step(1'b1);

      // Command and ID together: command first, ID next cycle
      step(1'b1, 16'h4007, 1'b1, 8'h07, 1'b1);
      chk("dest_after_retarget", 32'(dut.r_dest), 32'h07);
      step(1'b0, 16'h0000, 1'b1, 8'h07, 1'b1);
      idle_step(1'b1);

      // ID with high bits set never matches; reset mid-move with buzzer active
      step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 8'h45, 1'b1);
      idle_step(1'b1);
      for (int k = 0; k < 6; k++) idle_step(1'b0);
      do_reset();
      idle_step(1'b1);

      // Randomized traffic with a well-behaved producer
      cr = 1'b0; iv = 1'b0; ok = 1'b1; c = 16'h0000; id = 8'h00;
      for (int n = 0; n < 800; n++) begin
         if (!cr && ($urandom % 3 == 0)) begin
            cr = 1'b1;
            c  = 16'($urandom);
            c[5:0] = 6'($urandom_range(0, 7));
            if ($urandom % 2 == 0) c[15:14] = 2'b01;
         end
         if (!iv && ($urandom % 2 == 0)) begin
            iv = 1'b1;
            id = ($urandom % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         end
         if ($urandom % 8 == 0) ok = ~ok;
         step(cr, c, iv, id, ok);
         if (cr) cr = 1'b0;
         else if (iv) iv = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
